// File: rtl/input_cond_pkg.sv
// Shared constants and helpers for the switch/button input conditioner.
package input_cond_pkg;

    localparam int N_SW                    = 16;
    localparam int N_PB                    = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    // Counter width able to hold 0..cycles.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/input_conditioner_debounce.sv
// One conditioned input: 2-FF synchroniser, counter debounce, rising-edge pulse.
module debounce_cell
    import input_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db,
    output logic rise
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
            $fatal(1, "DEBOUNCE_CYCLES must be >= 1");
        end
    endgenerate

    logic          s1_q, s2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q;

    // cnt tracks consecutive cycles in which s2 disagrees with the accepted level.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
        end else begin
            s1_q     <= raw;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= stable_d & ~stable_q;
        end
    end

    assign db   = stable_q;
    assign rise = rise_q;

endmodule

// File: rtl/input_conditioner.sv
// Conditions raw board switches and push buttons: sync + debounce per channel.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int N_SW            = input_cond_pkg::N_SW,
    parameter int N_PB            = input_cond_pkg::N_PB,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_SW-1:0] sw_raw,
    input  logic [N_PB-1:0] pb_raw,
    output logic [N_SW-1:0] sw_db,
    output logic [N_PB-1:0] pb_db,
    output logic [N_PB-1:0] pb_rise
);

    genvar i;
    generate
        // Switches only need the level; their edge pulse is not used downstream.
        for (i = 0; i < N_SW; i++) begin : g_sw
            debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
                .clk  (clk),
                .rst_n(rst_n),
                .raw  (sw_raw[i]),
                .db   (sw_db[i]),
                .rise ()
            );
        end
        for (i = 0; i < N_PB; i++) begin : g_pb
            debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
                .clk  (clk),
                .rst_n(rst_n),
                .raw  (pb_raw[i]),
                .db   (pb_db[i]),
                .rise (pb_rise[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with DEBOUNCE_CYCLES = 4.
module tb_input_conditioner;

    localparam int DC = 4;
    localparam int NCH = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sw_raw = '0;
    logic [3:0]  pb_raw = '0;
    logic [15:0] sw_db;
    logic [3:0]  pb_db;
    logic [3:0]  pb_rise;

    int n_chk = 0;
    int n_fail = 0;

    input_conditioner #(.N_SW(16), .N_PB(4), .DEBOUNCE_CYCLES(DC)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw_raw (sw_raw),
        .pb_raw (pb_raw),
        .sw_db  (sw_db),
        .pb_db  (pb_db),
        .pb_rise(pb_rise)
    );

    always #5 clk = ~clk;

    // Model: raw sample history per edge; an output flips once the last DC
    // samples seen through the two-edge synchroniser delay all disagree with it.
    logic [NCH-1:0] hist [0:DC+1];
    logic [NCH-1:0] m_out = '0;
    logic [3:0]     m_rise = '0;
    bit             m_valid = 1'b0;

    initial for (int i = 0; i <= DC + 1; i++) hist[i] = '0;

    always @(posedge clk) begin
        logic [NCH-1:0] nxt;
        if (!rst_n) begin
            for (int i = 0; i <= DC + 1; i++) hist[i] = '0;
            m_out   = '0;
            m_rise  = '0;
            m_valid = 1'b1;
        end else begin
            for (int i = DC + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {pb_raw, sw_raw};
            nxt = m_out;
            for (int c = 0; c < NCH; c++) begin
                bit all_diff;
                all_diff = 1'b1;
                for (int k = 0; k < DC; k++)
                    if (hist[2+k][c] == m_out[c]) all_diff = 1'b0;
                if (all_diff) nxt[c] = ~m_out[c];
            end
            m_rise = nxt[19:16] & ~m_out[19:16];
            m_out  = nxt;
        end
    end

    int rise_cnt [4];

    always @(negedge clk) begin
        if (m_valid) begin
            n_chk += 3;
            if (sw_db !== m_out[15:0]) begin
                n_fail++;
                $display("FAIL model_sw_db t=%0t got %h want %h", $time, sw_db, m_out[15:0]);
            end
            if (pb_db !== m_out[19:16]) begin
                n_fail++;
                $display("FAIL model_pb_db t=%0t got %h want %h", $time, pb_db, m_out[19:16]);
            end
            if (pb_rise !== m_rise) begin
                n_fail++;
                $display("FAIL model_pb_rise t=%0t got %h want %h", $time, pb_rise, m_rise);
            end
            for (int j = 0; j < 4; j++) rise_cnt[j] += int'(pb_rise[j]);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_rise();
        for (int j = 0; j < 4; j++) rise_cnt[j] = 0;
    endtask

    initial begin
        for (int j = 0; j < 4; j++) rise_cnt[j] = 0;

        // Reset held with all inputs high, then release at edge r.
        sw_raw = 16'hFFFF; pb_raw = 4'hF; rst_n = 1'b0;
        edges(5);
        chk("rst_sw_db", 32'(sw_db), 32'h0);
        chk("rst_pb_rise", 32'(pb_rise), 32'h0);
        @(negedge clk); rst_n = 1'b1; clr_rise();
        edges(5);                            // edges r..r+4
        chk("rel_sw_db_r4", 32'(sw_db), 32'h0);
        edges(1);                            // edge r+5
        chk("rel_sw_db_r5", 32'(sw_db), 32'hFFFF);
        chk("rel_pb_db_r5", 32'(pb_db), 32'hF);
        chk("rel_pb_rise_r5", 32'(pb_rise), 32'hF);
        edges(1);
        chk("rel_pb_rise_r6", 32'(pb_rise), 32'h0);

        // Back to idle: buttons fall with no pulse.
        @(negedge clk); sw_raw = '0; pb_raw = '0; clr_rise();
        edges(8);
        chk("idle_sw_db", 32'(sw_db), 32'h0);
        chk("idle_fall_no_rise", 32'(rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3]), 32'd0);

        // Single switch on and off.
        @(negedge clk); sw_raw[3] = 1'b1;
        edges(5);
        chk("sw3_on_k4", 32'(sw_db), 32'h0);
        edges(1);
        chk("sw3_on_k5", 32'(sw_db), 32'h0008);
        chk("sw3_on_pb", 32'(pb_db), 32'h0);
        @(negedge clk); sw_raw[3] = 1'b0;
        edges(5);
        chk("sw3_off_k4", 32'(sw_db), 32'h0008);
        edges(1);
        chk("sw3_off_k5", 32'(sw_db), 32'h0);

        // Glitch of 3 cycles on pb0 must be rejected.
        @(negedge clk); pb_raw[0] = 1'b1; clr_rise();
        repeat (3) @(negedge clk);
        pb_raw[0] = 1'b0;
        edges(10);
        chk("glitch_pb_db", 32'(pb_db), 32'h0);
        chk("glitch_rise_cnt", 32'(rise_cnt[0]), 32'd0);

        // Bounce on pb2 then settle high.
        clr_rise();
        for (int t = 0; t < 10; t++) begin
            @(negedge clk); pb_raw[2] = (t % 2 == 0);
        end
        @(negedge clk); pb_raw[2] = 1'b1;
        edges(5);
        chk("bounce_s4", 32'(pb_db), 32'h0);
        edges(1);
        chk("bounce_s5", 32'(pb_db), 32'h4);
        edges(6);
        chk("bounce_rise_cnt", 32'(rise_cnt[2]), 32'd1);
        @(negedge clk); pb_raw[2] = 1'b0;
        edges(8);
        chk("bounce_fall_db", 32'(pb_db), 32'h0);
        chk("bounce_fall_rise_cnt", 32'(rise_cnt[2]), 32'd1);

        // Reset in the middle of a count (cnt == 2 at edge k+4).
        @(negedge clk); pb_raw[1] = 1'b1;
        edges(4);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        chk("midrst_pb_db", 32'(pb_db), 32'h0);
        edges(5);
        chk("midrst_r4", 32'(pb_db), 32'h0);
        edges(1);
        chk("midrst_r5", 32'(pb_db), 32'h2);
        @(negedge clk); pb_raw[1] = 1'b0;
        edges(8);

        // All inputs toggled together.
        @(negedge clk); sw_raw = 16'hFFFF; pb_raw = 4'hF; clr_rise();
        edges(5);
        chk("par_k4", {12'h0, pb_db, sw_db}, 32'h0);
        edges(1);
        chk("par_k5", {12'h0, pb_db, sw_db}, 32'hFFFFF);
        chk("par_rise_k5", 32'(pb_rise), 32'hF);
        edges(1);
        chk("par_rise_k6", 32'(pb_rise), 32'h0);
        @(negedge clk); sw_raw = '0; pb_raw = '0;
        edges(5);
        chk("par_off_k4", {12'h0, pb_db, sw_db}, 32'hFFFFF);
        edges(1);
        chk("par_off_k5", {12'h0, pb_db, sw_db}, 32'h0);
        edges(2);
        chk("par_rise_total", 32'(rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3]), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
